// File: rtl/wired_pkg.sv
// rtl/wired_pkg.sv - shared types, default sizes and one-hot select helpers for the wired issue queue
package wired_pkg;

    localparam int IQ_SIZE_DEF = 8;
    localparam int CDB_CNT_DEF = 2;
    localparam int DATA_W_DEF  = 32;
    localparam int TAG_W_DEF   = 6;
    localparam int OP_W_DEF    = 16;
    localparam int SEL_MAX     = 64;

    typedef struct packed {
        logic                  rdy;
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] data;
    } iq_src_t;

    typedef struct packed {
        logic                 busy;
        logic [OP_W_DEF-1:0]  op;
        logic [TAG_W_DEF-1:0] tag;
        iq_src_t [1:0]        src;
    } iq_entry_t;

    // Index of the lowest set bit, -1 when none.
    function automatic int lowest_set(input logic [SEL_MAX-1:0] v);
        int r;
        r = -1;
        for (int i = SEL_MAX - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Index of the highest set bit, -1 when none.
    function automatic int highest_set(input logic [SEL_MAX-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < SEL_MAX; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/wired_iq_entry.sv
// rtl/wired_iq_entry.sv - one issue-queue slot with CDB wakeup, dispatch bypass and busy tracking
module wired_iq_entry
    import wired_pkg::*;
#(
    parameter int CDB_CNT = CDB_CNT_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int OP_W    = OP_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             alloc_i,
    input  logic                             clear_i,
    input  logic [OP_W-1:0]                  op_i,
    input  logic [TAG_W-1:0]                 tag_i,
    input  logic [1:0]                       src_rdy_i,
    input  logic [1:0][TAG_W-1:0]            src_tag_i,
    input  logic [1:0][DATA_W-1:0]           src_data_i,
    input  logic [CDB_CNT-1:0]               cdb_valid_i,
    input  logic [CDB_CNT-1:0][TAG_W-1:0]    cdb_tag_i,
    input  logic [CDB_CNT-1:0][DATA_W-1:0]   cdb_data_i,
    output logic                             busy_o,
    output logic [OP_W-1:0]                  op_o,
    output logic [TAG_W-1:0]                 tag_o,
    output logic [1:0]                       src_rdy_o,
    output logic [1:0][DATA_W-1:0]           src_data_o
);

    logic                   busy_q, busy_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic [1:0]             rdy_q, rdy_d;
    logic [1:0][TAG_W-1:0]  stag_q, stag_d;
    logic [1:0][DATA_W-1:0] data_q, data_d;

    always_comb begin
        busy_d = busy_q;
        op_d   = op_q;
        tag_d  = tag_q;
        rdy_d  = rdy_q;
        stag_d = stag_q;
        data_d = data_q;
        if (alloc_i) begin
            busy_d = 1'b1;
            op_d   = op_i;
            tag_d  = tag_i;
            rdy_d  = src_rdy_i;
            stag_d = src_tag_i;
            data_d = src_data_i;
        end else if (clear_i) begin
            busy_d = 1'b0;
        end
        // The same compare serves the dispatch bypass and the wakeup of a resident source;
        // scanning downward lets the lowest CDB port win.
        for (int s = 0; s < 2; s++) begin
            if ((alloc_i && !src_rdy_i[s]) || (!alloc_i && busy_q && !rdy_q[s])) begin
                for (int k = CDB_CNT - 1; k >= 0; k--) begin
                    if (cdb_valid_i[k] && (cdb_tag_i[k] == stag_d[s])) begin
                        rdy_d[s]  = 1'b1;
                        data_d[s] = cdb_data_i[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= 1'b0;
        else     busy_q <= busy_d;
    end

    always_ff @(posedge clk) begin
        op_q   <= op_d;
        tag_q  <= tag_d;
        rdy_q  <= rdy_d;
        stag_q <= stag_d;
        data_q <= data_d;
    end

    assign busy_o     = busy_q;
    assign op_o       = op_q;
    assign tag_o      = tag_q;
    assign src_rdy_o  = rdy_q;
    assign src_data_o = data_q;

endmodule

// File: rtl/wired_int_iq.sv
// rtl/wired_int_iq.sv - two-wide dispatch, two-port issue integer queue with positional priority
module wired_int_iq
    import wired_pkg::*;
#(
    parameter int IQ_SIZE = IQ_SIZE_DEF,
    parameter int CDB_CNT = CDB_CNT_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int OP_W    = OP_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       p_valid_i,
    input  logic [1:0][OP_W-1:0]             p_op_i,
    input  logic [1:0][TAG_W-1:0]            p_tag_i,
    input  logic [1:0][1:0]                  p_src_rdy_i,
    input  logic [1:0][1:0][TAG_W-1:0]       p_src_tag_i,
    input  logic [1:0][1:0][DATA_W-1:0]      p_src_data_i,
    output logic                             p_ready_o,
    input  logic [CDB_CNT-1:0]               cdb_valid_i,
    input  logic [CDB_CNT-1:0][TAG_W-1:0]    cdb_tag_i,
    input  logic [CDB_CNT-1:0][DATA_W-1:0]   cdb_data_i,
    output logic [1:0]                       is_valid_o,
    input  logic [1:0]                       is_ready_i,
    output logic [1:0][OP_W-1:0]             is_op_o,
    output logic [1:0][TAG_W-1:0]            is_tag_o,
    output logic [1:0][1:0][DATA_W-1:0]      is_src_o,
    input  logic                             flush_i
);

    logic [IQ_SIZE-1:0]     busy, free, elig, clear;
    logic [OP_W-1:0]        e_op   [IQ_SIZE];
    logic [TAG_W-1:0]       e_tag  [IQ_SIZE];
    logic [1:0]             e_rdy  [IQ_SIZE];
    logic [1:0][DATA_W-1:0] e_data [IQ_SIZE];

    int free_cnt, a0_idx, a1_idx, lo_idx, hi_idx;
    int sel [2];

    logic [1:0]                  accept, take, v_q, v_d;
    logic [1:0][OP_W-1:0]        cand_op, op_q;
    logic [1:0][TAG_W-1:0]       cand_tag, tag_q;
    logic [1:0][1:0][DATA_W-1:0] cand_src, src_q;

    assign free = ~busy;

    always_comb begin
        free_cnt = 0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            free_cnt = free_cnt + (free[i] ? 1 : 0);
        end
        a0_idx = lowest_set(SEL_MAX'(free));
        a1_idx = highest_set(SEL_MAX'(free));
    end

    assign p_ready_o = (free_cnt >= 2) && !flush_i;

    for (genvar g = 0; g < IQ_SIZE; g++) begin : g_ent
        logic alloc0, alloc1;
        assign alloc0   = p_ready_o && p_valid_i[0] && (a0_idx == g);
        assign alloc1   = p_ready_o && p_valid_i[1] && (a1_idx == g);
        assign elig[g]  = busy[g] && ((&e_rdy[g]) || flush_i);
        assign clear[g] = (take[0] && (sel[0] == g)) || (take[1] && (sel[1] == g));

        wired_iq_entry #(
            .CDB_CNT (CDB_CNT),
            .DATA_W  (DATA_W),
            .TAG_W   (TAG_W),
            .OP_W    (OP_W)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .alloc_i     (alloc0 || alloc1),
            .clear_i     (clear[g]),
            .op_i        (alloc1 ? p_op_i[1]       : p_op_i[0]),
            .tag_i       (alloc1 ? p_tag_i[1]      : p_tag_i[0]),
            .src_rdy_i   (alloc1 ? p_src_rdy_i[1]  : p_src_rdy_i[0]),
            .src_tag_i   (alloc1 ? p_src_tag_i[1]  : p_src_tag_i[0]),
            .src_data_i  (alloc1 ? p_src_data_i[1] : p_src_data_i[0]),
            .cdb_valid_i (cdb_valid_i),
            .cdb_tag_i   (cdb_tag_i),
            .cdb_data_i  (cdb_data_i),
            .busy_o      (busy[g]),
            .op_o        (e_op[g]),
            .tag_o       (e_tag[g]),
            .src_rdy_o   (e_rdy[g]),
            .src_data_o  (e_data[g])
        );
    end

    assign accept = ~v_q | is_ready_i;

    // Port 0 prefers the lowest eligible entry; when port 0 is blocked, port 1 inherits it.
    always_comb begin
        lo_idx = lowest_set(SEL_MAX'(elig));
        hi_idx = highest_set(SEL_MAX'(elig));
        take   = 2'b00;
        sel[0] = lo_idx;
        sel[1] = hi_idx;
        if (accept[0]) begin
            take[0] = (lo_idx >= 0);
            take[1] = accept[1] && (hi_idx != lo_idx);
        end else if (accept[1]) begin
            take[1] = (lo_idx >= 0);
            sel[1]  = lo_idx;
        end
    end

    always_comb begin
        cand_op  = '0;
        cand_tag = '0;
        cand_src = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (sel[p] == i) begin
                    cand_op[p]  = e_op[i];
                    cand_tag[p] = e_tag[i];
                    cand_src[p] = e_data[i];
                end
            end
        end
    end

    always_comb begin
        v_d = v_q;
        for (int p = 0; p < 2; p++) begin
            if (accept[p]) v_d[p] = take[p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) v_q <= 2'b00;
        else     v_q <= v_d;
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (accept[p] && take[p]) begin
                op_q[p]  <= cand_op[p];
                tag_q[p] <= cand_tag[p];
                src_q[p] <= cand_src[p];
            end
        end
    end

    assign is_valid_o = v_q;
    assign is_op_o    = op_q;
    assign is_tag_o   = tag_q;
    assign is_src_o   = src_q;

endmodule

// File: doc/wired_int_iq.md
WIRED_INT_IQ -- requirements
Module: wired_int_iq

Interface
REQ-001 SHALL take parameter IQ_SIZE, default 8: entry count, at least 4.
REQ-002 SHALL take parameter CDB_CNT, default 2: number of CDB snoop ports.
REQ-003 SHALL take parameter DATA_W, default 32: operand width.
REQ-004 SHALL take parameter TAG_W, default 6: ROB tag width.
REQ-005 SHALL take parameter OP_W, default 16: opcode/control payload width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port p_valid_i, input, [1:0]: per-lane dispatch valid.
REQ-009 SHALL have port p_op_i, input, [1:0][OP_W]: op payload.
REQ-010 SHALL have port p_tag_i, input, [1:0][TAG_W]: destination tag.
REQ-011 SHALL have port p_src_rdy_i, input, [1:0][1:0]: per-source operand present.
REQ-012 SHALL have port p_src_tag_i, input, [1:0][1:0][TAG_W]: producer tag per source.
REQ-013 SHALL have port p_src_data_i, input, [1:0][1:0][DATA_W]: operand data.
REQ-014 SHALL have port p_ready_o, output, 1 bit: both lanes accepted this cycle.
REQ-015 SHALL have ports cdb_valid_i [CDB_CNT], cdb_tag_i [CDB_CNT][TAG_W] and cdb_data_i [CDB_CNT][DATA_W], all inputs: wakeup broadcast.
REQ-016 SHALL have ports is_valid_o [1:0] (output) and is_ready_i [1:0] (input): issue handshake per FU port.
REQ-017 SHALL have ports is_op_o, is_tag_o and is_src_o ([1:0][1:0][DATA_W]), all outputs: issued payload.
REQ-018 SHALL have port flush_i, input, 1 bit: drain mode; issue regardless of operand readiness.

Function
REQ-019 SHALL hold per entry: busy, op, tag, and two sources of {rdy, tag, data}; an entry is eligible when it is busy and both rdy are set, or when busy and flush_i=1.
REQ-020 SHALL drive p_ready_o = (free entries >= 2) & !flush_i, combinationally from registered state only.
REQ-021 SHALL allocate on dispatch when p_ready_o=1: lane 0 takes the lowest-index empty entry; lane 1 takes the highest-index empty entry; a lane with p_valid_i=0 allocates nothing.
REQ-022 SHALL capture a CDB broadcast that matches a dispatching source tag in the same cycle: rdy=1, data from the CDB; this same-cycle dispatch bypass takes priority over p_src_data_i.
REQ-023 SHALL, when cdb_valid_i[k] and tag match a busy entry's unready source, set rdy and latch data at the clock edge; the lowest k wins on multiple matches.
REQ-024 SHALL select issue candidates each cycle: port 0 takes the lowest-index eligible entry; port 1 takes the highest-index eligible entry, only if it differs from port 0's.
REQ-025 SHALL hold a registered output stage per port; a port accepts a new candidate when is_valid_o=0 or is_ready_i=1 in that cycle.
REQ-026 SHALL clear an entry's busy bit in the cycle it moves into an output stage; the entry is allocatable the next cycle.
REQ-027 SHALL have minimum latency of one cycle from dispatch to eligible, and one cycle from eligible to is_valid_o.
REQ-028 SHALL let a CDB wakeup at cycle t make the entry eligible at t+1 and give is_valid_o at t+2.
REQ-029 SHALL treat each output stage as a stall-safe handshake: while is_valid_o=1 and is_ready_i=0, the payload stays stable.
REQ-030 SHALL only issue to port 1 if port 1 is free; if only port 1 is free, the lowest eligible entry goes to port 1.
REQ-031 SHALL allow dispatch into entries freed in the same cycle only from the next cycle on; full/empty status uses registered busy bits.
REQ-032 SHALL, when flush_i=1, accept no dispatch and issue the eligible entries at up to two per cycle until all are empty.
REQ-033 SHALL apply no wrap-around or age ordering: priority is positional only.

Reset
REQ-034 SHALL, while rst=1, clear all busy bits and drive is_valid_o=0; p_ready_o=1 from the first cycle after release.
REQ-035 SHALL, on reset asserted mid-operation, discard all entries and output stages without issuing them; data registers need no reset.

Structure
REQ-036 SHALL place iq_src_t {rdy, tag, data}, iq_entry_t and the default constants in the shared wired package.
REQ-037 SHALL use one sub-module, wired_iq_entry: a single entry with CDB compare/wakeup and busy set/clear, instantiated IQ_SIZE times; leading-one and leading-zero selection uses the existing package one-hot macros.

Verification
REQ-038 SHALL cover this scenario: reset, then dispatch two fully-ready ops (tags 3,4) -> entries 0 and 7 busy; next cycle both is_valid_o=1 with tags 3/4 on ports 0/1.
REQ-039 SHALL cover this scenario: dispatch op with src0 tag 9 unready; CDB tag 9, data 0xDEADBEEF at cycle t -> is_valid_o[0]=1 at t+2 with is_src_o[0][0]=0xDEADBEEF.
REQ-040 SHALL cover this scenario: dispatch with src tag 5 while the CDB broadcasts tag 5, data 0x55 the same cycle -> entry captured ready, issues the next cycle with data 0x55.
REQ-041 SHALL cover this scenario: fill 8 entries, none ready -> p_ready_o=0 at 7 and 8 busy; one wakeup and issue -> p_ready_o stays 0 until 2 free.
REQ-042 SHALL cover this scenario: is_ready_i=0 for 3 cycles with valid issue -> payload stable, no entry lost; release -> next eligible issues the following cycle.
REQ-043 SHALL cover this scenario: 6 unready entries with flush_i=1 -> p_ready_o=0, all six issued within 3 cycles plus stalls, queue empty.
